fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 18 +
 rtl/fetch_ctrl_pc_fifo.sv | 54 +++++
 rtl/fetch_ctrl.sv | 132 +++++++++++++
 tb/tb_fetch_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared cpu package: address width, fetch packet size and fetch FSM state encoding.
package fetch_ctrl_pkg;

    localparam int CPU_ADDR_BITS = 32;
    localparam int FETCH_BYTES   = 8;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    // Counter/pointer width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fetch_ctrl_pc_fifo.sv
// In-order FIFO of request PCs awaiting an icache response; head reads 0 when empty.
module pc_fifo
    import fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = CPU_ADDR_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head
);

    localparam int PW = clog2_min1(DEPTH);
    localparam int CW = clog2_min1(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_push  = push && !w_full;
    assign w_pop   = pop && !w_empty;
    assign head    = w_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues two-instruction icache requests under buffer
// credits and an outstanding limit, and discards responses made stale by a redirect.
//
//   state | meaning
//   BOOT  | one idle cycle after reset, no requests
//   RUN   | normal fetch; redirect_val moves to FLUSH
//   FLUSH | one cycle: buf_flush high, credits rebuilt from pending drops
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [CPU_ADDR_BITS-1:0] RESET_PC        = 32'h0000_0000,
    parameter int                       BUF_DEPTH       = 4,
    parameter int                       MAX_OUTSTANDING = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     redirect_val,
    input  logic [CPU_ADDR_BITS-1:0] redirect_pc,
    input  logic                     stall,
    output logic                     icache_req_val,
    output logic [CPU_ADDR_BITS-1:0] icache_req_addr,
    input  logic                     icache_req_rdy,
    input  logic                     icache_resp_val,
    output logic                     buf_wr_val,
    output logic [CPU_ADDR_BITS-1:0] buf_wr_pc,
    input  logic                     buf_pop,
    output logic                     buf_flush
);

    localparam int OW = clog2_min1(MAX_OUTSTANDING + 1);
    localparam int CW = clog2_min1(BUF_DEPTH);
    localparam int XW = CW + 2;
    localparam logic [XW-1:0] CRED_MAX = XW'(BUF_DEPTH - 1);

    fetch_state_e             r_state;
    fetch_state_e             w_state_nxt;
    logic [CPU_ADDR_BITS-1:0] r_fetch_pc;
    logic [CPU_ADDR_BITS-1:0] w_fetch_pc_nxt;
    logic [OW-1:0]            r_outstanding;
    logic [OW-1:0]            w_outstanding_nxt;
    logic [OW-1:0]            r_drop_cnt;
    logic [OW-1:0]            w_drop_cnt_nxt;
    logic [CW-1:0]            r_credits;
    logic [CW-1:0]            w_credits_nxt;
    logic [XW-1:0]            w_cred_sum;
    logic                     w_resp_ok;
    logic                     w_dropped;
    logic                     w_redirect;
    logic                     w_accept;
    logic [CPU_ADDR_BITS-1:0] w_head_pc;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_resp_ok  = icache_resp_val && (r_outstanding != '0);
    assign w_dropped  = w_resp_ok && (r_drop_cnt != '0);
    assign w_redirect = (r_state == RUN) && redirect_val;

    assign icache_req_val  = (r_state == RUN) && !stall && !redirect_val &&
                             (r_credits != '0) && (r_outstanding < OW'(MAX_OUTSTANDING));
    assign w_accept        = icache_req_val && icache_req_rdy;
    assign icache_req_addr = r_fetch_pc;
    assign buf_wr_val      = w_resp_ok && (r_drop_cnt == '0);
    assign buf_wr_pc       = w_head_pc;
    assign buf_flush       = (r_state == FLUSH);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BOOT:    w_state_nxt = RUN;
            RUN:     if (redirect_val) w_state_nxt = FLUSH;
            FLUSH:   w_state_nxt = RUN;
            default: w_state_nxt = BOOT;
        endcase
    end

    always_comb begin
        w_fetch_pc_nxt = r_fetch_pc;
        if (w_redirect)
            w_fetch_pc_nxt = redirect_pc;
        else if (w_accept)
            w_fetch_pc_nxt = r_fetch_pc + CPU_ADDR_BITS'(FETCH_BYTES);

        w_outstanding_nxt = r_outstanding + OW'(w_accept) - OW'(w_resp_ok);

        // Everything still in flight at a redirect belongs to the old path.
        w_drop_cnt_nxt = r_drop_cnt - OW'(w_dropped);
        if (w_redirect)
            w_drop_cnt_nxt = r_outstanding - OW'(w_resp_ok);

        w_cred_sum = XW'(r_credits) + XW'(buf_pop) + XW'(w_dropped);
        if (w_accept && (w_cred_sum != '0))
            w_cred_sum = w_cred_sum - XW'(1);
        if (w_cred_sum > CRED_MAX)
            w_cred_sum = CRED_MAX;
        // Buffer is empty after the flush; only still-pending drops hold credits.
        if (r_state == FLUSH)
            w_cred_sum = (XW'(w_drop_cnt_nxt) >= CRED_MAX) ? '0 : CRED_MAX - XW'(w_drop_cnt_nxt);
        w_credits_nxt = CW'(w_cred_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BOOT;
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_credits     <= CW'(BUF_DEPTH - 1);
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_drop_cnt    <= w_drop_cnt_nxt;
            r_credits     <= w_credits_nxt;
        end
    end

    pc_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (CPU_ADDR_BITS)
    ) u_pc_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_accept),
        .din   (r_fetch_pc),
        .pop   (w_resp_ok),
        .head  (w_head_pc)
    );

    resp_without_request: assert property (
        @(posedge clk) disable iff (!rst_n) icache_resp_val |-> (r_outstanding != '0)
    ) else $error("icache response with no outstanding request");

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, multi-cycle reset/back-pressure
// sequences, then random traffic against a queue-based reference model.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_val;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        icache_req_val;
    logic [31:0] icache_req_addr;
    logic        icache_req_rdy;
    logic        icache_resp_val;
    logic        buf_wr_val;
    logic [31:0] buf_wr_pc;
    logic        buf_pop;
    logic        buf_flush;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    fetch_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_val    (redirect_val),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .icache_req_val  (icache_req_val),
        .icache_req_addr (icache_req_addr),
        .icache_req_rdy  (icache_req_rdy),
        .icache_resp_val (icache_resp_val),
        .buf_wr_val      (buf_wr_val),
        .buf_wr_pc       (buf_wr_pc),
        .buf_pop         (buf_pop),
        .buf_flush       (buf_flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st, rdy, rv;
        logic [31:0] rpc;
        logic        rsp, pp;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_wr;
        logic [31:0] e_wr_pc;
        logic        e_flush;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } ent_t;

    vec_t        vecs[$];
    ent_t        mq[$];
    int          m_phase;
    logic [31:0] m_pc;
    int          m_cred;

    function automatic vec_t mk(input logic st, rdy, rv, input logic [31:0] rpc,
                                input logic rsp, pp, e_req, input logic [31:0] e_addr,
                                input logic e_wr, input logic [31:0] e_wr_pc, input logic e_flush);
        vec_t v;
        v.st = st; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.rsp = rsp; v.pp = pp;
        v.e_req = e_req; v.e_addr = e_addr; v.e_wr = e_wr; v.e_wr_pc = e_wr_pc; v.e_flush = e_flush;
        return v;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b, want %b", nm, act, exp);
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    endtask

    task automatic drive(input logic st, rdy, rv, input logic [31:0] rpc, input logic rsp, pp);
        stall = st; icache_req_rdy = rdy; redirect_val = rv; redirect_pc = rpc;
        icache_resp_val = rsp; buf_pop = pp;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 32'h0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        //            st rdy rv rpc           rsp pp | req addr          wr wr_pc     flush
        vecs.push_back(mk(0, 1, 1, 32'h500,      0, 0,   0, 32'h0,        0, 32'h0,   0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0,   1, 32'h0,        0, 32'h0,   0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 0,   1, 32'h8,        1, 32'h0,   0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 0,   1, 32'h10,       1, 32'h8,   0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 0,   0, 32'h18,       1, 32'h10,  0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0,   0, 32'h18,       0, 32'h0,   0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1,   0, 32'h18,       0, 32'h0,   0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 1,   1, 32'h18,       0, 32'h0,   0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0,   1, 32'h20,       0, 32'h0,   0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1,   0, 32'h28,       0, 32'h0,   0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0,   0, 32'h28,       0, 32'h0,   0));
        vecs.push_back(mk(0, 0, 1, 32'h100,      0, 0,   0, 32'h28,       0, 32'h0,   0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 1,   0, 32'h100,      0, 32'h0,   1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 0,   0, 32'h100,      0, 32'h0,   0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 0,   1, 32'h100,      0, 32'h0,   0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0,   1, 32'h100,      0, 32'h0,   0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0,   1, 32'h108,      0, 32'h0,   0));
        vecs.push_back(mk(0, 1, 1, 32'h200,      1, 0,   0, 32'h110,      1, 32'h100, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0,   0, 32'h200,      0, 32'h0,   1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 0,   1, 32'h200,      0, 32'h0,   0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,   1, 32'h200,      0, 32'h0,   0));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 0,   0, 32'h200,      0, 32'h0,   0));
        vecs.push_back(mk(0, 0, 1, 32'hFFFFFFF8, 0, 0,   0, 32'h200,      0, 32'h0,   0));
        vecs.push_back(mk(0, 1, 1, 32'h300,      0, 0,   0, 32'hFFFFFFF8, 0, 32'h0,   1));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0,   1, 32'hFFFFFFF8, 0, 32'h0,   0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0,   1, 32'h0,        0, 32'h0,   0));

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].rdy, vecs[i].rv, vecs[i].rpc, vecs[i].rsp, vecs[i].pp);
            chk1($sformatf("v%0d req_val", i), icache_req_val, vecs[i].e_req);
            chk32($sformatf("v%0d req_addr", i), icache_req_addr, vecs[i].e_addr);
            chk1($sformatf("v%0d buf_wr_val", i), buf_wr_val, vecs[i].e_wr);
            if (vecs[i].e_wr) chk32($sformatf("v%0d buf_wr_pc", i), buf_wr_pc, vecs[i].e_wr_pc);
            chk1($sformatf("v%0d buf_flush", i), buf_flush, vecs[i].e_flush);
            tick();
        end

        // Back-pressure from reset: address holds, nothing counted as outstanding.
        do_reset();
        drive(0, 0, 0, 32'h0, 0, 0);
        chk1("boot req_val", icache_req_val, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 32'h0, 0, 0);
            chk1($sformatf("bp%0d req_val", i), icache_req_val, 1'b1);
            chk32($sformatf("bp%0d req_addr", i), icache_req_addr, 32'h0);
            tick();
        end
        drive(0, 1, 0, 32'h0, 0, 0);
        chk32("bp accept0 addr", icache_req_addr, 32'h0);
        tick();
        drive(0, 1, 0, 32'h0, 0, 0);
        chk1("bp accept1 req_val", icache_req_val, 1'b1);
        chk32("bp accept1 addr", icache_req_addr, 32'h8);
        tick();
        drive(0, 1, 0, 32'h0, 0, 0);
        chk1("bp cap req_val", icache_req_val, 1'b0);

        // Asynchronous reset with two requests in flight and a response pending.
        drive(0, 0, 0, 32'h0, 1, 0);
        chk1("pre-rst buf_wr_val", buf_wr_val, 1'b1);
        chk32("pre-rst buf_wr_pc", buf_wr_pc, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("rst req_val", icache_req_val, 1'b0);
        chk1("rst buf_wr_val", buf_wr_val, 1'b0);
        chk1("rst buf_flush", buf_flush, 1'b0);
        chk32("rst req_addr", icache_req_addr, 32'h0);
        chk32("rst buf_wr_pc", buf_wr_pc, 32'h0);
        drive(0, 0, 0, 32'h0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 1, 0, 32'h0, 0, 0);
        chk1("post-rst boot req_val", icache_req_val, 1'b0);
        tick();
        drive(0, 1, 0, 32'h0, 0, 0);
        chk1("post-rst req_val", icache_req_val, 1'b1);
        chk32("post-rst req_addr", icache_req_addr, 32'h0);
        tick();

        // Random traffic against the reference model.
        do_reset();
        mq.delete();
        m_phase = 0;
        m_pc    = 32'h0;
        m_cred  = 3;
        for (int c = 0; c < 3000; c++) begin
            logic        s, r, rv, rs, pp;
            logic [31:0] rpc;
            bit          e_req, e_wr, e_flush, acc, drp;
            int          n;
            s   = ($urandom_range(7) == 0);
            r   = ($urandom_range(3) != 0);
            rv  = ($urandom_range(15) == 0);
            rpc = $urandom() & 32'hFFFF_FFF8;
            rs  = (mq.size() > 0) && ($urandom_range(1) == 1);
            pp  = ($urandom_range(1) == 1);
            drive(s, r, rv, rpc, rs, pp);

            e_req   = (m_phase == 1) && !s && !rv && (m_cred > 0) && (mq.size() < 2);
            e_wr    = rs && !mq[0].stale;
            e_flush = (m_phase == 2);
            chk1("rnd req_val", icache_req_val, e_req);
            chk32("rnd req_addr", icache_req_addr, m_pc);
            chk1("rnd buf_wr_val", buf_wr_val, e_wr);
            if (e_wr) chk32("rnd buf_wr_pc", buf_wr_pc, mq[0].pc);
            chk1("rnd buf_flush", buf_flush, e_flush);

            acc = e_req && r;
            drp = rs && mq[0].stale;
            if (rs) void'(mq.pop_front());
            if (acc) begin
                mq.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 32'd8;
            end
            if (m_phase == 2) begin
                n = 0;
                foreach (mq[k]) if (mq[k].stale) n++;
                m_cred  = (n >= 3) ? 0 : 3 - n;
                m_phase = 1;
            end else begin
                m_cred = m_cred - int'(acc) + int'(pp) + int'(drp);
                if (m_cred > 3) m_cred = 3;
                if (m_cred < 0) m_cred = 0;
                if (m_phase == 1 && rv) begin
                    m_pc = rpc;
                    foreach (mq[k]) mq[k].stale = 1'b1;
                    m_phase = 2;
                end else if (m_phase == 0) begin
                    m_phase = 1;
                end
            end
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
